bcd_to_bin: RTL
===============

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have parameter NDIG, default 3: number of BCD input digits.
REQ-002 The block SHALL have parameter BW, default 10: binary result width; legal only when 2^BW >= 10^NDIG.
REQ-003 The block SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  in  1: the BCD operand is presented.
REQ-006 The block SHALL have port in_ready  out  1: the block can accept an operand.
REQ-007 The block SHALL have port bcd  in  4*NDIG: packed digits, most significant digit in the top nibble.
REQ-008 The block SHALL have port out_valid  out  1: the result is presented.
REQ-009 The block SHALL have port out_ready  in  1: the consumer accepts the result.
REQ-010 The block SHALL have port bin  out  BW: binary result.
REQ-011 The block SHALL have port err  out  1: the operand contained a nibble greater than 9.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and DONE; reset state is IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 An operand SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; bcd is sampled only on that edge.
REQ-015 On acceptance, if every nibble is at most 9, the block SHALL load a shift register {bcd, BW'b0}, clear the cycle counter and enter CONV.
REQ-016 On acceptance, if any nibble is greater than 9, the block SHALL set err=1 and bin=0 and go directly to DONE with no conversion.
REQ-017 Each CONV cycle SHALL shift the register right by 1, then subtract 3 from every BCD digit field that is 8 or greater (reverse double-dabble).
REQ-018 After exactly BW CONV cycles, the low BW bits of the register SHALL be latched into bin, err SHALL be set to 0 and the FSM SHALL enter DONE.
REQ-019 Latency SHALL be out_valid=1 BW+1 edges after the acceptance edge for a valid operand, and 1 edge after it for an err operand.
REQ-020 In DONE, bin and err SHALL hold stable until an edge with out_ready=1, then the FSM SHALL return to IDLE.
REQ-021 There SHALL be no same-cycle DONE-to-accept bypass; back-to-back throughput is one operand per BW+2 cycles.
REQ-022 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-023 Arithmetic SHALL be unsigned; a legal operand can never overflow BW bits, and no saturation logic is required.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, counter=0, shift register=0, bin=0, err=0 and out_valid=0, giving in_ready=1.
REQ-025 Reset asserted mid-CONV or in DONE SHALL discard the operation, and no result SHALL be emitted afterwards.
REQ-026 Deassertion of rst_n SHALL be the only release mechanism; there SHALL be no synchronous clear input.

Structure
REQ-027 Package bcd_pkg SHALL hold the state enum (IDLE, CONV, DONE), the default NDIG and BW constants, and the BCD digit-max constant 9.
REQ-028 Sub-module bcd_digit_adj SHALL be used: a 4-bit combinational function that subtracts 3 when the input is 8 or greater, instantiated NDIG times under a generate loop.
REQ-029 The cycle counter SHALL be $clog2(BW+1) bits wide.

Verification
REQ-030 bcd=12'h000 accepted -> after 11 edges out_valid=1, bin=0, err=0.
REQ-031 bcd=12'h999 -> bin=10'd999 (10'b1111100111), err=0, 11 edges after acceptance.
REQ-032 Exhaustive sweep of 0..999 -> bin equals the decimal value every time; for 0..99, the result fed back into the existing binbcd module reproduces the original digits.
REQ-033 bcd=12'h0A5 -> 1 edge later out_valid=1, err=1, bin=0; the FSM returns to IDLE after out_ready.
REQ-034 Result 12'h042 with out_ready held low for 5 cycles -> out_valid, bin=42 and in_ready=0 stay stable; a new in_valid is ignored until the handshake completes.
REQ-035 rst_n pulsed low during the 4th CONV cycle -> outputs clear immediately, no out_valid follows, and in_ready=1 after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NDIG = 3;
   localparam int DEF_BW   = 10;

   localparam logic [3:0] DIGIT_MAX = 4'd9;
   // A digit field of 8 or more after the right shift carried a "ten" down into this field.
   localparam logic [3:0] ADJ_MIN   = 4'd8;
   localparam logic [3:0] ADJ_SUB   = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit of the reverse double-dabble correction: subtract 3 from fields of 8 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= ADJ_MIN) ? (digit - ADJ_SUB) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per CONV cycle.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int NDIG = DEF_NDIG,
   parameter int BW   = DEF_BW
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NDIG-1:0] bcd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BW-1:0]     bin,
   output logic              err
);

   localparam int SW = 4*NDIG + BW;
   localparam int CW = $clog2(BW+1);

   state_t        state, nextState;
   logic [SW-1:0] shiftReg;
   logic [SW-1:0] shifted;
   logic [SW-1:0] adjusted;
   logic [CW-1:0] count;
   logic          badDigit;
   logic          lastShift;

   assign shifted   = shiftReg >> 1;
   assign lastShift = (count == CW'(BW-1));

   // The binary half of the register passes through untouched; only digit fields are corrected.
   assign adjusted[BW-1:0] = shifted[BW-1:0];

   for (genvar i = 0; i < NDIG; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (shifted[BW+4*i +: 4]),
         .adjusted (adjusted[BW+4*i +: 4])
      );
   end

   always_comb begin
      badDigit = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] > DIGIT_MAX) badDigit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (in_valid)  nextState = badDigit ? DONE : CONV;
         CONV:    if (lastShift) nextState = DONE;
         DONE:    if (out_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // The final shift latches its own corrected value so CONV lasts exactly BW cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shiftReg <= '0;
         count    <= '0;
         bin      <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (badDigit) begin
                     err <= 1'b1;
                     bin <= '0;
                  end else begin
                     shiftReg <= {bcd, {BW{1'b0}}};
                     count    <= '0;
                  end
               end
            end
            CONV: begin
               shiftReg <= adjusted;
               count    <= count + CW'(1);
               if (lastShift) begin
                  bin <= adjusted[BW-1:0];
                  err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
